// File: rtl/identity_resp_checker.sv
// identity_resp_checker
// Compares the reference-design and netlist output words sample by sample.
// It counts compared and mismatching samples and records the first failure.
// It also folds each stream into a rotate-xor signature.
// A run is framed by start/stop pulses and gives a pass/fail verdict in DONE.
module identity_resp_checker #(
    parameter int WIDTH  = 82,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_xor,
    output logic [WIDTH-1:0] sig_ref,
    output logic [WIDTH-1:0] sig_dut
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The settle counter only has to reach SETTLE-1; keep it at least one bit
    // wide so the SETTLE=0 build still elaborates.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // A start pulse skips SETTLE entirely when no samples are discarded.
    localparam state_t ENTRY_STATE = (SETTLE > 0) ? S_SETTLE : S_RUN;

    state_t             state_reg, state_next;
    logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [CNT_W-1:0]   sample_count_reg, sample_count_next;
    logic [CNT_W-1:0]   mismatch_count_reg, mismatch_count_next;
    logic [CNT_W-1:0]   first_fail_idx_reg, first_fail_idx_next;
    logic [WIDTH-1:0]   first_fail_xor_reg, first_fail_xor_next;
    logic [WIDTH-1:0]   sig_ref_reg, sig_ref_next;
    logic [WIDTH-1:0]   sig_dut_reg, sig_dut_next;

    logic [WIDTH-1:0]   sig_ref_rot;
    logic [WIDTH-1:0]   sig_dut_rot;
    logic [WIDTH-1:0]   diff;
    logic               is_mismatch;

    // Rotate-left-by-one of both signatures, bit by bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign sig_ref_rot[gi] = sig_ref_reg[(gi + WIDTH - 1) % WIDTH];
            assign sig_dut_rot[gi] = sig_dut_reg[(gi + WIDTH - 1) % WIDTH];
        end
    endgenerate

    assign diff        = y_ref ^ y_dut;
    assign is_mismatch = (diff != '0);

    // State and result registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_IDLE;
            settle_cnt_reg     <= '0;
            sample_count_reg   <= '0;
            mismatch_count_reg <= '0;
            first_fail_idx_reg <= '0;
            first_fail_xor_reg <= '0;
            sig_ref_reg        <= '0;
            sig_dut_reg        <= '0;
        end else begin
            state_reg          <= state_next;
            settle_cnt_reg     <= settle_cnt_next;
            sample_count_reg   <= sample_count_next;
            mismatch_count_reg <= mismatch_count_next;
            first_fail_idx_reg <= first_fail_idx_next;
            first_fail_xor_reg <= first_fail_xor_next;
            sig_ref_reg        <= sig_ref_next;
            sig_dut_reg        <= sig_dut_next;
        end
    end

    // Next-state and compare/signature step; start overrides everything.
    always_comb begin
        state_next          = state_reg;
        settle_cnt_next     = settle_cnt_reg;
        sample_count_next   = sample_count_reg;
        mismatch_count_next = mismatch_count_reg;
        first_fail_idx_next = first_fail_idx_reg;
        first_fail_xor_next = first_fail_xor_reg;
        sig_ref_next        = sig_ref_reg;
        sig_dut_next        = sig_dut_reg;

        if (start) begin
            state_next          = ENTRY_STATE;
            settle_cnt_next     = '0;
            sample_count_next   = '0;
            mismatch_count_next = '0;
            first_fail_idx_next = '0;
            first_fail_xor_next = '0;
            sig_ref_next        = '0;
            sig_dut_next        = '0;
        end else begin
            case (state_reg)
                S_SETTLE: begin
                    // Discarded samples only advance the settle counter.
                    if (sample_en) begin
                        if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
                            state_next      = S_RUN;
                            settle_cnt_next = '0;
                        end else begin
                            settle_cnt_next = settle_cnt_reg + 1'b1;
                        end
                    end
                    if (stop) begin
                        state_next = S_DONE;
                    end
                end
                S_RUN: begin
                    if (sample_en) begin
                        if (sample_count_reg != '1) begin
                            sample_count_next = sample_count_reg + 1'b1;
                        end
                        if (is_mismatch) begin
                            if (mismatch_count_reg != '1) begin
                                mismatch_count_next = mismatch_count_reg + 1'b1;
                            end
                            // mismatch_count never returns to zero inside a run,
                            // so zero here marks the first failure.
                            if (mismatch_count_reg == '0) begin
                                first_fail_idx_next = sample_count_reg;
                                first_fail_xor_next = diff;
                            end
                        end
                        sig_ref_next = sig_ref_rot ^ y_ref;
                        sig_dut_next = sig_dut_rot ^ y_dut;
                    end
                    // A sample arriving with stop is still processed above.
                    if (stop) begin
                        state_next = S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE ignore samples and hold their results.
                end
            endcase
        end
    end

    assign busy           = (state_reg == S_SETTLE) || (state_reg == S_RUN);
    assign done           = (state_reg == S_DONE);
    assign pass           = done && (mismatch_count_reg == '0) && (sample_count_reg != '0);
    assign sample_count   = sample_count_reg;
    assign mismatch_count = mismatch_count_reg;
    assign first_fail_idx = first_fail_idx_reg;
    assign first_fail_xor = first_fail_xor_reg;
    assign sig_ref        = sig_ref_reg;
    assign sig_dut        = sig_dut_reg;

endmodule

// File: tb/tb_identity_resp_checker.sv
// Bench for identity_resp_checker: three instances share the stimulus.
//   inst 0: WIDTH=8, CNT_W=16, SETTLE=0
//   inst 1: WIDTH=8, CNT_W=16, SETTLE=2
//   inst 2: WIDTH=8, CNT_W=2,  SETTLE=0
// A run-level reference model is checked every cycle.  A directed vector
// table drives inst 0, and short sequences cover settle and saturation.
module tb_identity_resp_checker;

    logic       clk = 1'b0;
    logic       rst, start, stop, sample_en;
    logic [7:0] y_ref, y_dut;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sc;
        logic [15:0] mc;
        logic [15:0] ffi;
        logic [7:0]  ffx;
        logic [7:0]  sr;
        logic [7:0]  sd;
    } obs_t;

    obs_t obs [3];

    logic        b0, dn0, ps0, b1, dn1, ps1, b2, dn2, ps2;
    logic [15:0] sc0, mc0, ffi0, sc1, mc1, ffi1;
    logic [1:0]  sc2, mc2, ffi2;
    logic [7:0]  ffx0, sr0, sd0, ffx1, sr1, sd1, ffx2, sr2, sd2;

    identity_resp_checker #(.WIDTH(8), .CNT_W(16), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .y_ref(y_ref), .y_dut(y_dut), .busy(b0), .done(dn0), .pass(ps0),
        .sample_count(sc0), .mismatch_count(mc0), .first_fail_idx(ffi0),
        .first_fail_xor(ffx0), .sig_ref(sr0), .sig_dut(sd0));

    identity_resp_checker #(.WIDTH(8), .CNT_W(16), .SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .y_ref(y_ref), .y_dut(y_dut), .busy(b1), .done(dn1), .pass(ps1),
        .sample_count(sc1), .mismatch_count(mc1), .first_fail_idx(ffi1),
        .first_fail_xor(ffx1), .sig_ref(sr1), .sig_dut(sd1));

    identity_resp_checker #(.WIDTH(8), .CNT_W(2), .SETTLE(0)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .y_ref(y_ref), .y_dut(y_dut), .busy(b2), .done(dn2), .pass(ps2),
        .sample_count(sc2), .mismatch_count(mc2), .first_fail_idx(ffi2),
        .first_fail_xor(ffx2), .sig_ref(sr2), .sig_dut(sd2));

    assign obs[0] = {b0, dn0, ps0, sc0, mc0, ffi0, ffx0, sr0, sd0};
    assign obs[1] = {b1, dn1, ps1, sc1, mc1, ffi1, ffx1, sr1, sd1};
    assign obs[2] = {b2, dn2, ps2, 14'd0, sc2, 14'd0, mc2, 14'd0, ffi2, ffx2, sr2, sd2};

    int tests  = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Run-level model: phase 0=idle, 1=collecting, 2=finished.  skip is the
    // number of enabled samples still to be thrown away after start.
    int settle_p [3] = '{0, 2, 0};
    int cmax     [3] = '{65535, 65535, 3};
    int m_phase  [3];
    int m_skip   [3];
    int m_sc [3], m_mc [3], m_ffi [3], m_ffx [3], m_sr [3], m_sd [3];

    function automatic int rotl8(input int x);
        return ((x << 1) | (x >> 7)) & 8'hFF;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst || start) begin
                m_phase[k] = rst ? 0 : 1;
                m_skip[k]  = settle_p[k];
                m_sc[k] = 0; m_mc[k] = 0; m_ffi[k] = 0;
                m_ffx[k] = 0; m_sr[k] = 0; m_sd[k] = 0;
            end else if (m_phase[k] == 1) begin
                if (sample_en) begin
                    if (m_skip[k] > 0) begin
                        m_skip[k]--;
                    end else begin
                        if (y_ref != y_dut) begin
                            if (m_mc[k] == 0) begin
                                m_ffi[k] = m_sc[k];
                                m_ffx[k] = int'(y_ref ^ y_dut);
                            end
                            if (m_mc[k] < cmax[k]) m_mc[k]++;
                        end
                        if (m_sc[k] < cmax[k]) m_sc[k]++;
                        m_sr[k] = rotl8(m_sr[k]) ^ int'(y_ref);
                        m_sd[k] = rotl8(m_sd[k]) ^ int'(y_dut);
                    end
                end
                if (stop) m_phase[k] = 2;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m%0d_busy", k), int'(obs[k].busy), int'(m_phase[k] == 1));
            chk($sformatf("m%0d_done", k), int'(obs[k].done), int'(m_phase[k] == 2));
            chk($sformatf("m%0d_pass", k), int'(obs[k].pass),
                int'(m_phase[k] == 2 && m_mc[k] == 0 && m_sc[k] != 0));
            chk($sformatf("m%0d_sc", k),  int'(obs[k].sc),  m_sc[k]);
            chk($sformatf("m%0d_mc", k),  int'(obs[k].mc),  m_mc[k]);
            chk($sformatf("m%0d_ffi", k), int'(obs[k].ffi), m_ffi[k]);
            chk($sformatf("m%0d_ffx", k), int'(obs[k].ffx), m_ffx[k]);
            chk($sformatf("m%0d_sr", k),  int'(obs[k].sr),  m_sr[k]);
            chk($sformatf("m%0d_sd", k),  int'(obs[k].sd),  m_sd[k]);
        end
    endtask

    // One clock: drive inputs, take the edge, advance model, compare at +1.
    task automatic cycle(input bit r_i, input bit st_i, input bit sp_i,
                         input bit en_i, input logic [7:0] a, input logic [7:0] b);
        rst = r_i; start = st_i; stop = sp_i; sample_en = en_i;
        y_ref = a; y_dut = b;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        bit rst, st, sp, en;
        logic [7:0] r, d;
        bit e_busy, e_done, e_pass;
        int e_sc, e_mc, e_ffi;
        logic [7:0] e_ffx, e_sr, e_sd;
    } vec_t;

    vec_t vq [$];

    task automatic add(input bit r_i, input bit st_i, input bit sp_i, input bit en_i,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit eb, input bit ed, input bit ep,
                       input int esc, input int emc, input int effi,
                       input logic [7:0] effx, input logic [7:0] esr, input logic [7:0] esd);
        vec_t v;
        v = '{r_i, st_i, sp_i, en_i, a, b, eb, ed, ep, esc, emc, effi, effx, esr, esd};
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
        y_ref = '0; y_dut = '0;

        //   rst st sp en  ref    dut    busy done pass sc mc ffi ffx    sr     sd
        add(1, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00,  1, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h01, 8'h01,  1, 0, 0,  1, 0, 0, 8'h00, 8'h01, 8'h01);
        add(0, 0, 0, 1, 8'h02, 8'h02,  1, 0, 0,  2, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 1, 0, 8'h00, 8'h00,  0, 1, 1,  2, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h09, 8'h08,  0, 1, 1,  2, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00,  1, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'hA5, 8'hA5,  1, 0, 0,  1, 0, 0, 8'h00, 8'hA5, 8'hA5);
        add(0, 0, 0, 1, 8'h3C, 8'h34,  1, 0, 0,  2, 1, 1, 8'h08, 8'h77, 8'h7F);
        add(0, 0, 0, 1, 8'h11, 8'h10,  1, 0, 0,  3, 2, 1, 8'h08, 8'hFF, 8'hEE);
        add(0, 0, 1, 0, 8'h00, 8'h00,  0, 1, 0,  3, 2, 1, 8'h08, 8'hFF, 8'hEE);
        add(0, 1, 0, 0, 8'h00, 8'h00,  1, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 1, 1, 8'h80, 8'h81,  0, 1, 0,  1, 1, 0, 8'h01, 8'h80, 8'h81);
        add(0, 1, 0, 0, 8'h00, 8'h00,  1, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h01, 8'h00,  1, 0, 0,  1, 1, 0, 8'h01, 8'h01, 8'h00);
        add(0, 0, 0, 1, 8'h02, 8'h00,  1, 0, 0,  2, 2, 0, 8'h01, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h04, 8'h00,  1, 0, 0,  3, 3, 0, 8'h01, 8'h04, 8'h00);
        add(0, 1, 1, 1, 8'h33, 8'h44,  1, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h55, 8'hAA,  1, 0, 0,  1, 1, 0, 8'hFF, 8'h55, 8'hAA);
        add(1, 0, 0, 1, 8'h12, 8'h34,  0, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 1, 0, 8'h00, 8'h00,  0, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 8'h66, 8'h77,  0, 0, 0,  0, 0, 0, 8'h00, 8'h00, 8'h00);

        foreach (vq[i]) begin
            cycle(vq[i].rst, vq[i].st, vq[i].sp, vq[i].en, vq[i].r, vq[i].d);
            chk($sformatf("v%0d_busy", i), int'(obs[0].busy), int'(vq[i].e_busy));
            chk($sformatf("v%0d_done", i), int'(obs[0].done), int'(vq[i].e_done));
            chk($sformatf("v%0d_pass", i), int'(obs[0].pass), int'(vq[i].e_pass));
            chk($sformatf("v%0d_sc", i),   int'(obs[0].sc),   vq[i].e_sc);
            chk($sformatf("v%0d_mc", i),   int'(obs[0].mc),   vq[i].e_mc);
            chk($sformatf("v%0d_ffi", i),  int'(obs[0].ffi),  vq[i].e_ffi);
            chk($sformatf("v%0d_ffx", i),  int'(obs[0].ffx),  int'(vq[i].e_ffx));
            chk($sformatf("v%0d_sr", i),   int'(obs[0].sr),   int'(vq[i].e_sr));
            chk($sformatf("v%0d_sd", i),   int'(obs[0].sd),   int'(vq[i].e_sd));
            $display("[TB] vec %0d rst=%0d st=%0d sp=%0d en=%0d ref=%h dut=%h -> sc=%0d mc=%0d done=%0d pass=%0d",
                     i, vq[i].rst, vq[i].st, vq[i].sp, vq[i].en, vq[i].r, vq[i].d,
                     obs[0].sc, obs[0].mc, obs[0].done, obs[0].pass);
        end

        // Settle discard on the SETTLE=2 instance.
        cycle(0, 1, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 0, 1, 8'hFF, 8'h00);
        cycle(0, 0, 0, 1, 8'hFF, 8'h00);
        cycle(0, 0, 0, 1, 8'h07, 8'h07);
        cycle(0, 0, 1, 0, 8'h00, 8'h00);
        chk("settle_sc",   int'(obs[1].sc),   1);
        chk("settle_mc",   int'(obs[1].mc),   0);
        chk("settle_pass", int'(obs[1].pass), 1);
        chk("settle_sr",   int'(obs[1].sr),   8'h07);
        $display("[TB] settle run: sc=%0d mc=%0d pass=%0d sig_ref=%h",
                 obs[1].sc, obs[1].mc, obs[1].pass, obs[1].sr);

        // Stop during SETTLE ends the run with no samples, so no pass.
        cycle(0, 1, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 0, 1, 8'h01, 8'h01);
        cycle(0, 0, 1, 0, 8'h00, 8'h00);
        chk("settle_stop_done", int'(obs[1].done), 1);
        chk("settle_stop_pass", int'(obs[1].pass), 0);
        $display("[TB] settle stop: done=%0d pass=%0d", obs[1].done, obs[1].pass);

        // Saturation on the CNT_W=2 instance.
        cycle(0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'(i + 1), 8'h00);
        cycle(0, 0, 1, 0, 8'h00, 8'h00);
        chk("sat_sc",   int'(obs[2].sc),   3);
        chk("sat_mc",   int'(obs[2].mc),   3);
        chk("sat_ffi",  int'(obs[2].ffi),  0);
        chk("sat_ffx",  int'(obs[2].ffx),  8'h01);
        chk("sat_pass", int'(obs[2].pass), 0);
        $display("[TB] saturation: sc=%0d mc=%0d ffi=%0d", obs[2].sc, obs[2].mc, obs[2].ffi);

        // Random traffic against the model on all three instances.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a, b;
            bit r_i, st_i, sp_i, en_i;
            r_i  = ($urandom_range(99) == 0);
            st_i = ($urandom_range(29) == 0);
            sp_i = ($urandom_range(19) == 0);
            en_i = ($urandom_range(9) < 6);
            a    = 8'($urandom);
            b    = ($urandom_range(1) == 0) ? a : 8'($urandom);
            cycle(r_i, st_i, sp_i, en_i, a, b);
        end
        $display("[TB] random phase: 1500 cycles compared against model");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/identity_resp_checker.md
Name: identity_resp_checker

Overview:
- Response-side checker for identity fuzz runs. It receives the per-clock output word from the reference design and from the synthesized netlist, compares them, and compacts each stream into a signature.
- It replaces per-cycle $strobe dumps with a pass/fail verdict and first-failure data.
- It sits after the two "top" instances in the simulation harness, sampling on the same posedge that stimulus is applied against.

Parameters:
- WIDTH, 82: width of compared output word (y is [81:0]).
- CNT_W, 16: width of sample and mismatch counters.
- SETTLE, 1: number of enabled samples discarded after start, before comparison begins (0 allowed).

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; clears results and begins a run.
- stop  input  1  one-cycle pulse; ends the run.
- sample_en  input  1  y_ref/y_dut valid this cycle.
- y_ref  input  WIDTH  reference design output.
- y_dut  input  WIDTH  synthesized design output.
- busy  output  1  high in SETTLE or RUN.
- done  output  1  high in DONE until next start or rst.
- pass  output  1  valid when done; 1 iff mismatch_count==0 and sample_count!=0.
- sample_count  output  CNT_W  compared samples, saturating.
- mismatch_count  output  CNT_W  mismatching samples, saturating.
- first_fail_idx  output  CNT_W  sample_count value at first mismatch.
- first_fail_xor  output  WIDTH  y_ref^y_dut at first mismatch.
- sig_ref  output  WIDTH  reference stream signature.
- sig_dut  output  WIDTH  DUT stream signature.

Behaviour:
- Reset: state IDLE; every output is 0.
- FSM states: IDLE, SETTLE, RUN, DONE.
  - IDLE --start--> SETTLE if SETTLE>0, else RUN.
  - SETTLE: counts enabled samples; after SETTLE of them, moves to RUN. No compare and no signature update during SETTLE.
  - RUN --stop--> DONE.
  - SETTLE --stop--> DONE, with pass=0 since sample_count=0.
  - DONE --start--> SETTLE or RUN.
- start in any state, including mid-run, clears all counters, signatures and first_fail fields, then enters SETTLE or RUN on the next cycle. start has priority over stop.
- Compare step, in RUN when sample_en=1:
  - sample_count increments, saturating at all-ones.
  - If y_ref!=y_dut, mismatch_count increments (saturating).
  - If this is the first mismatch since start, first_fail_idx gets the pre-increment sample_count (0-based) and first_fail_xor gets y_ref^y_dut. These fields are then frozen.
- Signatures update on the same step:
  - sig_ref <= {sig_ref[WIDTH-2:0], sig_ref[WIDTH-1]} ^ y_ref
  - sig_dut <= {sig_dut[WIDTH-2:0], sig_dut[WIDTH-1]} ^ y_dut
- stop together with sample_en in RUN: the sample is processed, then the FSM enters DONE.
- Latency: all results registered, visible the cycle after the sampling edge. done and pass rise the cycle after stop.
- pass is combinational from the registered counters, gated by done; it is 0 whenever done=0.
- In IDLE and DONE, sample_en is ignored and results hold.
- Inputs are treated as 2-state. X/Z handling is the harness's job.

Test Plan:
- Bench uses WIDTH=8, SETTLE=0.
- Match run: start; samples (ref,dut)=(0x01,0x01),(0x02,0x02); stop -> done=1, pass=1, sample_count=2, mismatch_count=0, sig_ref=sig_dut=0x00 (rotl(0x01)^0x02).
- Single mismatch: start; samples (0xA5,0xA5),(0x3C,0x34),(0x11,0x10); stop -> mismatch_count=2, first_fail_idx=1, first_fail_xor=0x08, pass=0.
- Settle discard: SETTLE=2; start; samples (0xFF,0x00),(0xFF,0x00),(0x07,0x07); stop -> sample_count=1, mismatch_count=0, pass=1, sig_ref=0x07.
- Simultaneous stop+sample: the last sample (0x80,0x81) arrives with stop -> counted, mismatch_count=1, done=1 the next cycle.
- Restart and reset: start mid-run after 3 mismatches -> counters=0 next cycle, busy=1. Then rst during RUN -> all outputs 0, state IDLE, a subsequent stop is ignored (done=0).
- Saturation: CNT_W=2; 5 mismatching samples -> sample_count=3, mismatch_count=3, first_fail_idx=0.
